ucie_ctl_phy_sb_cfg_bridge: RTL and testbench

UCIE_CTL_PHY_SB_CFG_BRIDGE -- requirements
Module: UCIE_ctl_phy_sb_cfg_bridge

---
 rtl/ucie_ctl_phy_sb_pkg.sv | 7 +
 rtl/ucie_ctl_phy_sb_fifo.sv | 41 ++++
 rtl/ucie_ctl_phy_sb_cfg_bridge.sv | 98 +++++++++
 tb/tb_ucie_ctl_phy_sb_cfg_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucie_ctl_phy_sb_pkg.sv
// Default sizing shared by the RDI config <-> sideband bridge and its FIFOs.
package ucie_ctl_phy_sb_pkg;
  localparam int NC_DEF         = 32;
  localparam int TX_DEPTH_DEF   = 4;
  localparam int RX_DEPTH_DEF   = 4;
  localparam int RX_CRD_MAX_DEF = 8;
endpackage

// File: rtl/ucie_ctl_phy_sb_fifo.sv
// Small FIFO with combinational head; pointers carry an extra wrap bit for full/empty.
module ucie_ctl_phy_sb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // Storage is not reset: emptiness is decided purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= data;
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = mem[rd_ptr_reg[AW-1:0]];
endmodule

// File: rtl/ucie_ctl_phy_sb_cfg_bridge.sv
// Credit-controlled bridge between the RDI config channel (LP side) and the sideband link.
module ucie_ctl_phy_sb_cfg_bridge
  import ucie_ctl_phy_sb_pkg::*;
#(
  parameter int NC         = NC_DEF,
  parameter int TX_DEPTH   = TX_DEPTH_DEF,
  parameter int RX_DEPTH   = RX_DEPTH_DEF,
  parameter int RX_CRD_MAX = RX_CRD_MAX_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rdi_lp_cfg_valid,
  input  logic [NC-1:0] i_rdi_lp_cfg,
  output logic          o_rdi_pl_cfg_crd,
  input  logic          i_sb_tx_ready,
  output logic          o_sb_data_valid,
  output logic [NC-1:0] o_data_sent_sb,
  input  logic          i_sb_data_valid,
  input  logic [NC-1:0] i_data_received_sb,
  input  logic          i_rdi_lp_cfg_crd,
  output logic          o_rdi_pl_cfg_vld,
  output logic [NC-1:0] o_rdi_pl_cfg,
  output logic          o_tx_overflow,
  output logic          o_rx_overflow
);
  localparam int OW = $clog2(TX_DEPTH + 1);
  localparam int CW = $clog2(RX_CRD_MAX + 1);

  logic          tx_full, tx_empty, tx_push, tx_pop;
  logic [NC-1:0] tx_head;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic [NC-1:0] rx_head;

  logic [OW-1:0] owed_reg, owed_next;
  logic          crd_reg, crd_next;
  logic [CW-1:0] lp_crd_reg, lp_crd_next;
  logic          tx_ovf_reg, rx_ovf_reg;
  logic          pl_vld_reg;
  logic [NC-1:0] pl_cfg_reg;

  // A full FIFO still accepts a word when its head leaves in the same cycle.
  assign tx_pop  = !tx_empty && i_sb_tx_ready;
  assign tx_push = i_rdi_lp_cfg_valid && (!tx_full || tx_pop);
  assign rx_pop  = !rx_empty && (lp_crd_reg != '0);
  assign rx_push = i_sb_data_valid && (!rx_full || rx_pop);

  ucie_ctl_phy_sb_fifo #(.WIDTH(NC), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(tx_push), .data(i_rdi_lp_cfg),
    .pop(tx_pop), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  ucie_ctl_phy_sb_fifo #(.WIDTH(NC), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(i_clk), .rst_n(i_rst_n), .push(rx_push), .data(i_data_received_sb),
    .pop(rx_pop), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  always_comb begin
    crd_next  = (owed_reg != '0);
    owed_next = owed_reg;
    if (crd_next && !tx_pop)      owed_next = owed_reg - OW'(1);
    else if (!crd_next && tx_pop) owed_next = owed_reg + OW'(1);

    lp_crd_next = lp_crd_reg;
    if (i_rdi_lp_cfg_crd && !rx_pop) begin
      if (lp_crd_reg != CW'(RX_CRD_MAX)) lp_crd_next = lp_crd_reg + CW'(1);
    end else if (!i_rdi_lp_cfg_crd && rx_pop) begin
      lp_crd_next = lp_crd_reg - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owed_reg   <= OW'(TX_DEPTH);
      crd_reg    <= 1'b0;
      lp_crd_reg <= '0;
      tx_ovf_reg <= 1'b0;
      rx_ovf_reg <= 1'b0;
      pl_vld_reg <= 1'b0;
      pl_cfg_reg <= '0;
    end else begin
      owed_reg   <= owed_next;
      crd_reg    <= crd_next;
      lp_crd_reg <= lp_crd_next;
      pl_vld_reg <= rx_pop;
      if (rx_pop) pl_cfg_reg <= rx_head;
      if (i_rdi_lp_cfg_valid && tx_full && !tx_pop) tx_ovf_reg <= 1'b1;
      if (i_sb_data_valid && rx_full && !rx_pop)    rx_ovf_reg <= 1'b1;
    end
  end

  assign o_rdi_pl_cfg_crd = crd_reg;
  assign o_sb_data_valid  = !tx_empty;
  assign o_data_sent_sb   = tx_head;
  assign o_rdi_pl_cfg_vld = pl_vld_reg;
  assign o_rdi_pl_cfg     = pl_cfg_reg;
  assign o_tx_overflow    = tx_ovf_reg;
  assign o_rx_overflow    = rx_ovf_reg;
endmodule

// File: tb/tb_ucie_ctl_phy_sb_cfg_bridge.sv
// Bench for the config/sideband bridge: vector table, directed corner cases, random vs queue model.
module tb_ucie_ctl_phy_sb_cfg_bridge;
  import ucie_ctl_phy_sb_pkg::*;
  localparam int NC   = NC_DEF;
  localparam int TXD  = TX_DEPTH_DEF;
  localparam int RXD  = RX_DEPTH_DEF;
  localparam int CMAX = RX_CRD_MAX_DEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lp_valid = 1'b0, tx_ready = 1'b0, sb_valid = 1'b0, lp_crd = 1'b0;
  logic [NC-1:0] lp_cfg = '0, sb_data = '0;
  logic          pl_crd, sb_out_valid, pl_vld, tx_ovf, rx_ovf;
  logic [NC-1:0] sb_out_data, pl_cfg;

  ucie_ctl_phy_sb_cfg_bridge #(.NC(NC), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RX_CRD_MAX(CMAX)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rdi_lp_cfg_valid(lp_valid), .i_rdi_lp_cfg(lp_cfg), .o_rdi_pl_cfg_crd(pl_crd),
    .i_sb_tx_ready(tx_ready), .o_sb_data_valid(sb_out_valid), .o_data_sent_sb(sb_out_data),
    .i_sb_data_valid(sb_valid), .i_data_received_sb(sb_data), .i_rdi_lp_cfg_crd(lp_crd),
    .o_rdi_pl_cfg_vld(pl_vld), .o_rdi_pl_cfg(pl_cfg),
    .o_tx_overflow(tx_ovf), .o_rx_overflow(rx_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic lpv, input logic [NC-1:0] lpw, input logic rdy,
                        input logic sbv, input logic [NC-1:0] sbw, input logic lcrd);
    lp_valid = lpv; lp_cfg = lpw; tx_ready = rdy;
    sb_valid = sbv; sb_data = sbw; lp_crd = lcrd;
  endtask

  // Reference model: plain queues and counters following the bridge rules.
  logic [NC-1:0] m_txq[$];
  logic [NC-1:0] m_rxq[$];
  int            m_owed, m_credit;
  bit            m_crd, m_txovf, m_rxovf, m_vld;
  logic [NC-1:0] m_pl;

  task automatic model_reset();
    m_txq.delete(); m_rxq.delete();
    m_owed = TXD; m_credit = 0; m_crd = 0;
    m_txovf = 0; m_rxovf = 0; m_vld = 0; m_pl = '0;
  endtask

  task automatic model_step();
    bit tx_full_now, pop, rx_full_now, deliver;
    logic [NC-1:0] w;
    tx_full_now = (m_txq.size() == TXD);
    pop = (m_txq.size() > 0) && tx_ready;
    m_crd = (m_owed > 0);
    m_owed = m_owed - (m_crd ? 1 : 0) + (pop ? 1 : 0);
    if (pop) void'(m_txq.pop_front());
    if (lp_valid) begin
      if (!tx_full_now || pop) m_txq.push_back(lp_cfg);
      else m_txovf = 1;
    end
    rx_full_now = (m_rxq.size() == RXD);
    deliver = (m_rxq.size() > 0) && (m_credit > 0);
    m_vld = deliver;
    if (deliver) begin
      w = m_rxq.pop_front();
      m_pl = w;
    end
    if (sb_valid) begin
      if (!rx_full_now || deliver) m_rxq.push_back(sb_data);
      else m_rxovf = 1;
    end
    if (lp_crd && !deliver) m_credit = (m_credit < CMAX) ? m_credit + 1 : CMAX;
    else if (!lp_crd && deliver) m_credit = m_credit - 1;
  endtask

  task automatic model_check();
    chk("m_crd", pl_crd, m_crd);
    chk("m_sbv", sb_out_valid, m_txq.size() > 0);
    if (m_txq.size() > 0) chk("m_sbdata", sb_out_data, m_txq[0]);
    chk("m_txovf", tx_ovf, m_txovf);
    chk("m_vld", pl_vld, m_vld);
    chk("m_pl", pl_cfg, m_pl);
    chk("m_rxovf", rx_ovf, m_rxovf);
  endtask

  // Enters reset at a falling edge, checks reset values, releases on the next falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_in(0, '0, 0, 0, '0, 0);
    #1;
    chk("rst_crd", pl_crd, 1'b0);
    chk("rst_sbv", sb_out_valid, 1'b0);
    chk("rst_vld", pl_vld, 1'b0);
    chk("rst_pl", pl_cfg, '0);
    chk("rst_txovf", tx_ovf, 1'b0);
    chk("rst_rxovf", rx_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit            lpv;
    logic [NC-1:0] lpw;
    bit            rdy;
    bit            sbv;
    logic [NC-1:0] sbw;
    bit            lcrd;
    bit            e_crd;
    bit            e_sbv;
    logic [NC-1:0] e_data;
    bit            e_txovf;
    bit            e_vld;
    logic [NC-1:0] e_pl;
    bit            e_rxovf;
  } vec_t;

  vec_t tbl[13];
  logic [NC-1:0] got[$];
  int lp_cred;
  int pct_lp, pct_rdy, pct_sb, pct_crd;

  initial begin
    // Row i is driven and observed i rising edges after reset release.
    tbl[0]  = '{1, 32'hA5A5_0001, 0, 1, 32'hB0B0_0001, 0,  0, 0, 0,            0, 0, 0,            0};
    tbl[1]  = '{1, 32'hA5A5_0002, 0, 1, 32'hB0B0_0002, 0,  1, 1, 32'hA5A5_0001, 0, 0, 0,            0};
    tbl[2]  = '{1, 32'hA5A5_0003, 0, 1, 32'hB0B0_0003, 0,  1, 1, 32'hA5A5_0001, 0, 0, 0,            0};
    tbl[3]  = '{1, 32'hA5A5_0004, 0, 0, 0,             0,  1, 1, 32'hA5A5_0001, 0, 0, 0,            0};
    tbl[4]  = '{0, 0,             0, 0, 0,             0,  1, 1, 32'hA5A5_0001, 0, 0, 0,            0};
    tbl[5]  = '{1, 32'hA5A5_0005, 0, 0, 0,             0,  0, 1, 32'hA5A5_0001, 0, 0, 0,            0};
    tbl[6]  = '{0, 0,             1, 0, 0,             1,  0, 1, 32'hA5A5_0001, 1, 0, 0,            0};
    tbl[7]  = '{0, 0,             1, 0, 0,             1,  0, 1, 32'hA5A5_0002, 1, 0, 0,            0};
    tbl[8]  = '{0, 0,             1, 0, 0,             0,  1, 1, 32'hA5A5_0003, 1, 1, 32'hB0B0_0001, 0};
    tbl[9]  = '{0, 0,             1, 0, 0,             0,  1, 1, 32'hA5A5_0004, 1, 1, 32'hB0B0_0002, 0};
    tbl[10] = '{0, 0,             0, 0, 0,             0,  1, 0, 0,            1, 0, 32'hB0B0_0002, 0};
    tbl[11] = '{0, 0,             0, 0, 0,             0,  1, 0, 0,            1, 0, 32'hB0B0_0002, 0};
    tbl[12] = '{0, 0,             0, 0, 0,             0,  0, 0, 0,            1, 0, 32'hB0B0_0002, 0};

    // Vector table: credit init, TX backpressure/overflow, RX credit-gated delivery.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].lpv, tbl[i].lpw, tbl[i].rdy, tbl[i].sbv, tbl[i].sbw, tbl[i].lcrd);
      #1;
      chk($sformatf("vec%0d_crd", i), pl_crd, tbl[i].e_crd);
      chk($sformatf("vec%0d_sbv", i), sb_out_valid, tbl[i].e_sbv);
      if (tbl[i].e_sbv) chk($sformatf("vec%0d_sbdata", i), sb_out_data, tbl[i].e_data);
      chk($sformatf("vec%0d_txovf", i), tx_ovf, tbl[i].e_txovf);
      chk($sformatf("vec%0d_vld", i), pl_vld, tbl[i].e_vld);
      chk($sformatf("vec%0d_pl", i), pl_cfg, tbl[i].e_pl);
      chk($sformatf("vec%0d_rxovf", i), rx_ovf, tbl[i].e_rxovf);
      $display("vec %0d: crd=%0b sbv=%0b sbdata=%h vld=%0b pl=%h txovf=%0b rxovf=%0b",
               i, pl_crd, sb_out_valid, sb_out_data, pl_vld, pl_cfg, tx_ovf, rx_ovf);
      @(negedge clk);
    end

    // RX overflow: five words into a 4-deep FIFO with no credit, then five credits.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(0, '0, 0, 1, 32'hC0DE_0001 + i, 0);
      @(negedge clk);
    end
    set_in(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    #1;
    chk("rxovf_set", rx_ovf, 1'b1);
    chk("rxovf_novld", pl_vld, 1'b0);
    got.delete();
    for (int i = 0; i < 14; i++) begin
      set_in(0, '0, 0, 0, '0, (i < 5) ? 1'b1 : 1'b0);
      #1;
      if (pl_vld) got.push_back(pl_cfg);
      @(negedge clk);
    end
    chk("rxovf_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      chk($sformatf("rxovf_word%0d", i), got[i], 32'hC0DE_0001 + i);
      $display("rx deliver %0d: %h", i, got[i]);
    end
    chk("rxovf_sticky", rx_ovf, 1'b1);

    // Credit saturation: ten credits with an empty FIFO allow only eight deliveries.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_in(0, '0, 0, 0, '0, 1);
      @(negedge clk);
    end
    got.delete();
    for (int i = 0; i < 18; i++) begin
      if (i < 10) set_in(0, '0, 0, 1, 32'hD000_0001 + i, 0);
      else        set_in(0, '0, 0, 0, '0, 0);
      #1;
      if (pl_vld) got.push_back(pl_cfg);
      @(negedge clk);
    end
    chk("sat_count", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk($sformatf("sat_word%0d", i), got[i], 32'hD000_0001 + i);
    chk("sat_rxovf", rx_ovf, 1'b0);
    $display("saturation: %0d deliveries", got.size());

    // Reset with both FIFOs half full: words discarded, credit init repeats.
    do_reset();
    for (int i = 0; i < 6; i++) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      set_in(1, 32'hE000_0001 + i, 0, 1, 32'hF000_0001 + i, 0);
      @(negedge clk);
    end
    set_in(0, '0, 0, 0, '0, 0);
    #1;
    chk("mid_sbv_before", sb_out_valid, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("mid_crd%0d", i), pl_crd, (i >= 1 && i <= 4) ? 1'b1 : 1'b0);
      chk($sformatf("mid_sbv%0d", i), sb_out_valid, 1'b0);
      @(negedge clk);
    end
    got.delete();
    for (int i = 0; i < 8; i++) begin
      set_in(0, '0, 0, 0, '0, (i < 3) ? 1'b1 : 1'b0);
      #1;
      if (pl_vld) got.push_back(pl_cfg);
      @(negedge clk);
    end
    chk("mid_no_delivery", got.size(), 0);
    $display("mid-reset: deliveries after reset=%0d", got.size());

    // Random traffic vs model: first credit-respecting LP, then unconstrained.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      lp_cred = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        if (cyc % 100 == 0) begin
          pct_lp  = $urandom_range(10, 100);
          pct_rdy = $urandom_range(5, 100);
          pct_sb  = $urandom_range(5, 100);
          pct_crd = $urandom_range(5, 100);
        end
        #1;
        model_check();
        if (m_crd) lp_cred++;
        lp_valid = ($urandom_range(1, 100) <= pct_lp);
        if (phase == 0) begin
          if (lp_cred == 0) lp_valid = 1'b0;
          else if (lp_valid) lp_cred--;
        end
        lp_cfg   = $urandom;
        tx_ready = ($urandom_range(1, 100) <= pct_rdy);
        sb_valid = ($urandom_range(1, 100) <= pct_sb);
        sb_data  = $urandom;
        lp_crd   = ($urandom_range(1, 100) <= pct_crd);
        model_step();
        @(negedge clk);
      end
      if (phase == 0) chk("rand_no_txovf", tx_ovf, 1'b0);
      $display("random phase %0d done", phase);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
